ram_port_arbiter: RTL and testbench
===================================

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter START_DELAY, default 15; cycles from cpu_done capture to the rd_start pulse; legal range 1-255.
REQ-002 Parameter STARVE_LIMIT, default 8; consecutive denied readout cycles before readout takes priority; legal range 1-15.
REQ-003 clk  in  1  single system clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-005 cpu_req  in  1  CPU requests a RAM access this cycle.
REQ-006 cpu_we  in  1  1 = write, 0 = read; qualified by cpu_req.
REQ-007 cpu_addr  in  6  CPU RAM address.
REQ-008 cpu_wdata  in  16  CPU write data.
REQ-009 cpu_gnt  out  1  CPU access performed this cycle.
REQ-010 cpu_rvalid  out  1  cpu_rdata valid; the CPU read was granted in the previous cycle.
REQ-011 cpu_rdata  out  16  CPU read data.
REQ-012 rd_req  in  1  readout read request.
REQ-013 rd_addr  in  6  readout address.
REQ-014 rd_gnt  out  1  readout access performed this cycle.
REQ-015 rd_rvalid  out  1  rd_rdata valid; the readout read was granted in the previous cycle.
REQ-016 rd_rdata  out  16  readout read data.
REQ-017 ram_en  out  1  RAM enable.
REQ-018 ram_we  out  1  RAM write enable.
REQ-019 ram_addr  out  6  RAM address.
REQ-020 ram_din  out  16  RAM write data.
REQ-021 ram_dout  in  16  RAM read data; registered, 1-cycle latency.
REQ-022 cpu_done  in  1  CPU signals that the output image is complete (level).
REQ-023 rd_start  out  1  single-cycle start/reset pulse to the readout engine.

Function
REQ-024 Grant is combinational within the cycle.
- Default: cpu_req wins.
- Exception: when starve_cnt == STARVE_LIMIT and rd_req=1, readout wins.
REQ-025 At most one of cpu_gnt and rd_gnt is high in any cycle; a grant is high only when the matching req is high.
REQ-026 A denied requester keeps req, addr and data stable until granted; the arbiter stores no pending request.
REQ-027 RAM port per cycle:
- ram_en = cpu_gnt | rd_gnt.
- ram_we = cpu_gnt & cpu_we.
- ram_addr and ram_din come from the granted requester.
- With no grant, ram_addr = 0 and ram_din = 0.
REQ-028 Read return:
- cpu_rvalid is a register set to (cpu_gnt & ~cpu_we); rd_rvalid is a register set to rd_gnt.
- cpu_rdata and rd_rdata both carry ram_dout directly; they are valid only while the matching rvalid is high.
REQ-029 Writes produce no rvalid.
REQ-030 starve_cnt is a 4-bit register.
- Increments when rd_req & ~rd_gnt, saturating at STARVE_LIMIT.
- Clears to 0 when rd_gnt=1 or rd_req=0.
REQ-031 Start sequencer FSM states: IDLE, COUNT, PULSE, DONE.
REQ-032 IDLE: when cpu_done=1, go to COUNT and load dly_cnt=1.
REQ-033 COUNT: dly_cnt increments each cycle; when dly_cnt == START_DELAY, go to PULSE. Deasserting cpu_done in COUNT has no effect.
REQ-034 PULSE: rd_start=1 for exactly this one cycle, then go to DONE.
REQ-035 DONE: hold until reset; cpu_done is ignored and there is no further pulse.
REQ-036 rd_start is 1 only in PULSE (registered FSM decode, glitch-free).
REQ-037 Latency: cpu_done sampled high at edge N gives rd_start high in the cycle after edge N+START_DELAY.
REQ-038 Arbitration runs in every FSM state; the readout may request before DONE.

Reset
REQ-039 While reset=1:
- FSM = IDLE, dly_cnt = 0, starve_cnt = 0.
- cpu_rvalid = 0, rd_rvalid = 0, rd_start = 0.
- Grants and ram_en/ram_we are forced to 0.
REQ-040 Reset asserted mid-COUNT or mid-PULSE aborts the sequence with no pulse; after release, a new cpu_done starts a full START_DELAY count.
REQ-041 Reset asserted in the cycle after a read grant suppresses that rvalid.

Verification
REQ-042 CPU write then read: cpu_req=1, we=1, addr=5, wdata=16'hBEEF, then the same with we=0 -> cpu_gnt both cycles, ram_we=1 then 0, cpu_rvalid=1 one cycle later with cpu_rdata=16'hBEEF.
REQ-043 Contention: cpu_req and rd_req held high with STARVE_LIMIT=8 -> cpu_gnt for 8 cycles, rd_gnt on the 9th, then cpu_gnt again; never both grants high.
REQ-044 Readout alone: rd_req=1, rd_addr stepping 0..63 -> rd_gnt every cycle, rd_rvalid every cycle from the second cycle, data matching the preloaded RAM contents.
REQ-045 Start sequencing: cpu_done pulsed for 1 cycle at edge N, START_DELAY=15 -> rd_start high for exactly one cycle after edge N+15; a second cpu_done produces no pulse.
REQ-046 Reset mid-count: assert reset 7 cycles after cpu_done -> no rd_start; cpu_done after release -> pulse 15 cycles later.
REQ-047 Asynchronous reset between clock edges -> all outputs 0 immediately, without waiting for an edge.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Purpose: shares one single-port RAM between a CPU port and a readout port, and
//          sequences a delayed one-shot rd_start pulse after the CPU finishes.
// Latency: grants are combinational in the request cycle; read data returns one
//          cycle after the grant, which is when the matching rvalid is high.
// Backpressure: a denied requester holds its request until granted; readout
//          takes priority once it has been denied STARVE_LIMIT cycles in a row.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata -> cpu_gnt, cpu_rvalid, cpu_rdata   CPU access port
//   rd_req/rd_addr        -> rd_gnt, rd_rvalid, rd_rdata      readout port
//   ram_en/we/addr/din, ram_dout    RAM interface (1-cycle registered read)
//   cpu_done -> rd_start            image-complete level to delayed start pulse
module ram_port_arbiter #(
    parameter int START_DELAY  = 15,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [5:0]  cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,
    output logic [15:0] cpu_rdata,
    input  logic        rd_req,
    input  logic [5:0]  rd_addr,
    output logic        rd_gnt,
    output logic        rd_rvalid,
    output logic [15:0] rd_rdata,
    output logic        ram_en,
    output logic        ram_we,
    output logic [5:0]  ram_addr,
    output logic [15:0] ram_din,
    input  logic [15:0] ram_dout,
    input  logic        cpu_done,
    output logic        rd_start
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] COUNT = 2'd1;
    localparam logic [1:0] PULSE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [7:0] DELAY_MAX  = 8'(START_DELAY);

    logic [3:0] starve_cnt;
    logic       rd_wins;
    logic [1:0] state;
    logic [7:0] dly_cnt;

    // ------------------------------------------------------------------
    // Arbitration and RAM port mux
    // ------------------------------------------------------------------
    // Grants are gated by reset so the RAM sees no access while reset is
    // asserted, even between clock edges.
    always_comb begin
        rd_wins  = rd_req && (starve_cnt == STARVE_MAX);
        cpu_gnt  = !reset && cpu_req && !rd_wins;
        rd_gnt   = !reset && rd_req && (rd_wins || !cpu_req);
        ram_en   = cpu_gnt || rd_gnt;
        ram_we   = cpu_gnt && cpu_we;
        ram_addr = 6'd0;
        ram_din  = 16'd0;
        if (cpu_gnt) begin
            ram_addr = cpu_addr;
            ram_din  = cpu_wdata;
        end else if (rd_gnt) begin
            ram_addr = rd_addr;
        end
    end

    // Both ports see the RAM output; only the matching rvalid qualifies it.
    assign cpu_rdata = ram_dout;
    assign rd_rdata  = ram_dout;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_rvalid <= 1'b0;
            rd_rvalid  <= 1'b0;
        end else begin
            cpu_rvalid <= cpu_gnt && !cpu_we;
            rd_rvalid  <= rd_gnt;
        end
    end

    // Counts consecutive cycles the readout waited; saturates so priority
    // stays with readout until it is actually served.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= 4'd0;
        end else if (rd_gnt || !rd_req) begin
            starve_cnt <= 4'd0;
        end else if (starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // Start sequencer: one pulse per reset, START_DELAY cycles after cpu_done
    // ------------------------------------------------------------------
    // rd_start is its own flop, set on the transition into PULSE, so the
    // output never glitches through a state decode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            dly_cnt  <= 8'd0;
            rd_start <= 1'b0;
        end else begin
            rd_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_done) begin
                        state   <= COUNT;
                        dly_cnt <= 8'd1;
                    end
                end
                COUNT: begin
                    if (dly_cnt == DELAY_MAX) begin
                        state    <= PULSE;
                        rd_start <= 1'b1;
                    end else begin
                        dly_cnt <= dly_cnt + 8'd1;
                    end
                end
                PULSE: begin
                    state <= DONE;
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, rd_req, cpu_done;
    logic [5:0]  cpu_addr, rd_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_gnt, cpu_rvalid, rd_gnt, rd_rvalid;
    logic [15:0] cpu_rdata, rd_rdata;
    logic        ram_en, ram_we, rd_start;
    logic [5:0]  ram_addr;
    logic [15:0] ram_din, ram_dout;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ram_port_arbiter #(.START_DELAY(15), .STARVE_LIMIT(8)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_rvalid(rd_rvalid), .rd_rdata(rd_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout), .cpu_done(cpu_done), .rd_start(rd_start)
    );

    function automatic logic [15:0] init_word(int i);
        return 16'(i * 16'h0101) ^ 16'h5A3C;
    endfunction

    // RAM with 1-cycle registered read, preloaded on the first clock edge
    logic [15:0] mem [64];
    logic        loaded = 1'b0;
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
            loaded <= 1'b1;
        end else if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_din;
            else        ram_dout <= mem[ram_addr];
        end
    end

    // Reference contents and read-return scoreboard
    logic [15:0] ref_mem [64];
    typedef struct {
        logic        is_cpu;
        logic [15:0] data;
    } sb_t;
    sb_t  sbq[$];
    logic pend_cpu, pend_rd;

    typedef struct {
        logic        cpu_req;
        logic        cpu_we;
        logic [5:0]  cpu_addr;
        logic [15:0] cpu_wdata;
        logic        rd_req;
        logic [5:0]  rd_addr;
        logic        e_cpu_gnt;
        logic        e_rd_gnt;
    } vec_t;

    function automatic vec_t mk(logic cr, logic cw, logic [5:0] ca, logic [15:0] cd,
                                logic rr, logic [5:0] ra, logic ecg, logic erg);
        vec_t v;
        v.cpu_req = cr; v.cpu_we = cw; v.cpu_addr = ca; v.cpu_wdata = cd;
        v.rd_req = rr; v.rd_addr = ra; v.e_cpu_gnt = ecg; v.e_rd_gnt = erg;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compares read returns owed by the previous cycle's grants
    task automatic check_returns(string name);
        sb_t e;
        chk({name, "/cpu_rvalid"}, 32'(cpu_rvalid), 32'(pend_cpu));
        chk({name, "/rd_rvalid"},  32'(rd_rvalid),  32'(pend_rd));
        if (pend_cpu || pend_rd) begin
            chk({name, "/sb_depth"}, 32'(sbq.size()), 32'd1);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                if (e.is_cpu) chk({name, "/cpu_rdata"}, 32'(cpu_rdata), 32'(e.data));
                else          chk({name, "/rd_rdata"},  32'(rd_rdata),  32'(e.data));
            end
        end
    endtask

    task automatic apply(vec_t v, string name);
        logic [5:0]  ea;
        logic [15:0] ed;
        @(negedge clk);
        cpu_req = v.cpu_req; cpu_we = v.cpu_we; cpu_addr = v.cpu_addr;
        cpu_wdata = v.cpu_wdata; rd_req = v.rd_req; rd_addr = v.rd_addr;
        #1;
        check_returns(name);
        ea = v.e_cpu_gnt ? v.cpu_addr : (v.e_rd_gnt ? v.rd_addr : 6'd0);
        ed = v.e_cpu_gnt ? v.cpu_wdata : 16'd0;
        chk({name, "/cpu_gnt"},  32'(cpu_gnt),  32'(v.e_cpu_gnt));
        chk({name, "/rd_gnt"},   32'(rd_gnt),   32'(v.e_rd_gnt));
        chk({name, "/ram_en"},   32'(ram_en),   32'(v.e_cpu_gnt | v.e_rd_gnt));
        chk({name, "/ram_we"},   32'(ram_we),   32'(v.e_cpu_gnt & v.cpu_we));
        chk({name, "/ram_addr"}, 32'(ram_addr), 32'(ea));
        chk({name, "/ram_din"},  32'(ram_din),  32'(ed));
        pend_cpu = v.e_cpu_gnt & ~v.cpu_we;
        pend_rd  = v.e_rd_gnt;
        if (pend_cpu) sbq.push_back('{1'b1, ref_mem[v.cpu_addr]});
        if (pend_rd)  sbq.push_back('{1'b0, ref_mem[v.rd_addr]});
        if (v.e_cpu_gnt && v.cpu_we) ref_mem[v.cpu_addr] = v.cpu_wdata;
    endtask

    // Pulses cpu_done so it is sampled on exactly one edge, then watches
    // ncyc following edges; k counts edges after the sampling edge.
    task automatic done_and_watch(int ncyc, output int first, output int cnt);
        first = -1;
        cnt   = 0;
        @(negedge clk); cpu_done = 1'b1;
        @(negedge clk); cpu_done = 1'b0;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk); #1;
            if (rd_start) begin
                cnt++;
                if (first < 0) first = k;
            end
        end
    endtask

    task automatic watch_only(int ncyc, output int cnt);
        cnt = 0;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk); #1;
            if (rd_start) cnt++;
        end
    endtask

    vec_t tbl [8];
    vec_t idle_v;

    initial begin
        int first, cnt;
        logic rd_turn;

        reset = 1'b1; cpu_done = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        rd_req = 1'b0; rd_addr = '0;
        pend_cpu = 1'b0; pend_rd = 1'b0;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        idle_v = mk(0, 0, 6'd0, 16'h0, 0, 6'd0, 0, 0);

        // Reset state: requests present but nothing granted
        repeat (2) @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; rd_req = 1'b1;
        #1;
        chk("rst/cpu_gnt",    32'(cpu_gnt),    32'd0);
        chk("rst/rd_gnt",     32'(rd_gnt),     32'd0);
        chk("rst/ram_en",     32'(ram_en),     32'd0);
        chk("rst/ram_we",     32'(ram_we),     32'd0);
        chk("rst/cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        chk("rst/rd_rvalid",  32'(rd_rvalid),  32'd0);
        chk("rst/rd_start",   32'(rd_start),   32'd0);
        @(negedge clk);
        reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; rd_req = 1'b0;

        //          creq cwe caddr   cwdata    rreq raddr  egc erg
        tbl[0] = mk(0,   0,  6'd0,  16'h0000, 0,   6'd0,  0,  0);
        tbl[1] = mk(1,   1,  6'd5,  16'hBEEF, 0,   6'd0,  1,  0);
        tbl[2] = mk(1,   0,  6'd5,  16'hBEEF, 0,   6'd0,  1,  0);
        tbl[3] = mk(0,   0,  6'd0,  16'h0000, 1,   6'd9,  0,  1);
        tbl[4] = mk(1,   1,  6'd7,  16'h1234, 1,   6'd3,  1,  0);
        tbl[5] = mk(1,   0,  6'd7,  16'h0000, 0,   6'd0,  1,  0);
        tbl[6] = mk(0,   0,  6'd0,  16'h0000, 1,   6'd63, 0,  1);
        tbl[7] = mk(1,   0,  6'd0,  16'h0000, 0,   6'd0,  1,  0);
        for (int i = 0; i < 8; i++) apply(tbl[i], $sformatf("vec%0d", i));
        apply(idle_v, "drain0");

        // Contention: readout wins after 8 consecutive denials, then again 9 later
        for (int i = 0; i < 20; i++) begin
            rd_turn = (i == 8) || (i == 17);
            apply(mk(1, 0, 6'(i), 16'h0, 1, 6'(63 - i), !rd_turn, rd_turn),
                  $sformatf("cont%0d", i));
        end
        apply(idle_v, "drain1");

        // Readout sweep across the whole RAM
        for (int i = 0; i < 64; i++)
            apply(mk(0, 0, 6'd0, 16'h0, 1, 6'(i), 0, 1), $sformatf("sweep%0d", i));
        apply(idle_v, "drain2");
        chk("sb_empty", 32'(sbq.size()), 32'd0);

        // Start sequencing: one pulse, 15 edges after cpu_done is sampled
        done_and_watch(25, first, cnt);
        chk("start/first", 32'(first), 32'd15);
        chk("start/count", 32'(cnt),   32'd1);
        done_and_watch(25, first, cnt);
        chk("start2/count", 32'(cnt), 32'd0);

        // Reset mid-count aborts the sequence; a fresh cpu_done restarts it
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        @(negedge clk); cpu_done = 1'b1;
        @(negedge clk); cpu_done = 1'b0;
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk); #1;
        chk("midrst/rd_start", 32'(rd_start), 32'd0);
        reset = 1'b0;
        watch_only(25, cnt);
        chk("midrst/no_pulse", 32'(cnt), 32'd0);
        done_and_watch(25, first, cnt);
        chk("restart/first", 32'(first), 32'd15);
        chk("restart/count", 32'(cnt),   32'd1);

        // Asynchronous reset between edges, with a read return in flight
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 6'd5;
        @(negedge clk); #1;
        chk("async/pre_rvalid", 32'(cpu_rvalid), 32'd1);
        chk("async/pre_gnt",    32'(cpu_gnt),    32'd1);
        reset = 1'b1;
        #1;
        chk("async/cpu_gnt",    32'(cpu_gnt),    32'd0);
        chk("async/rd_gnt",     32'(rd_gnt),     32'd0);
        chk("async/ram_en",     32'(ram_en),     32'd0);
        chk("async/ram_we",     32'(ram_we),     32'd0);
        chk("async/ram_addr",   32'(ram_addr),   32'd0);
        chk("async/ram_din",    32'(ram_din),    32'd0);
        chk("async/cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        chk("async/rd_rvalid",  32'(rd_rvalid),  32'd0);
        chk("async/rd_start",   32'(rd_start),   32'd0);
        @(negedge clk);
        cpu_req = 1'b0;
        reset = 1'b0;
        @(negedge clk); #1;
        chk("async/post_rvalid", 32'(cpu_rvalid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
